// File: rtl/transition_decode.sv
// transition_decode: rebuilds the NA-bit two's-complement operand from its Booth transition vectors (P,N),
// decoding DW digits per clock LSB first and flagging encodings no operand can produce.
module transition_decode #(
    parameter int NA = 6,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NA-1:0] P_in,
    input  logic [NA-1:0] N_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NA-1:0] A_out,
    output logic          err_out,
    output logic          busy
);
    localparam int S  = NA / DW;
    localparam int SW = (S > 1) ? $clog2(S) : 1;

    if (DW < 1 || NA % DW != 0) begin : g_chk
        $error("transition_decode: NA must be a positive multiple of DW");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [NA-1:0] p_sh, n_sh, acc, acc_nx;
    logic [SW-1:0] step;
    logic          prev, err, last;
    logic [DW-1:0] grp;
    logic          grp_prev, grp_ill;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign last      = step == SW'(S - 1);

    always_comb begin
        state_nx = state;
        if (state == IDLE && in_valid) state_nx = RUN;
        if (state == RUN && last) state_nx = DONE;
        if (state == DONE && out_ready) state_nx = IDLE;
    end

    // A digit is legal only if it equals A[i-1]-A[i], i.e. +1 needs prev=1 and -1 needs prev=0
    always_comb begin
        grp_prev = prev;
        grp_ill  = 1'b0;
        grp      = '0;
        for (int i = 0; i < DW; i++) begin
            grp_ill  = grp_ill | (p_sh[i] & n_sh[i]) | (p_sh[i] & ~grp_prev) | (n_sh[i] & grp_prev);
            grp[i]   = grp_prev ^ (p_sh[i] | n_sh[i]);
            grp_prev = grp[i];
        end
    end

    if (NA == DW) begin : g_one
        assign acc_nx = grp;
    end else begin : g_shift
        assign acc_nx = {grp, acc[NA-1:DW]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_sh    <= '0;
            n_sh    <= '0;
            acc     <= '0;
            step    <= '0;
            prev    <= 1'b0;
            err     <= 1'b0;
            A_out   <= '0;
            err_out <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            p_sh <= P_in;
            n_sh <= N_in;
            acc  <= '0;
            step <= '0;
            prev <= 1'b0;
            err  <= 1'b0;
        end else if (state == RUN) begin
            p_sh <= p_sh >> DW;
            n_sh <= n_sh >> DW;
            acc  <= acc_nx;
            step <= step + 1'b1;
            prev <= grp_prev;
            err  <= err | grp_ill;
            if (last) begin
                A_out   <= acc_nx;
                err_out <= err | grp_ill;
            end
        end
    end
endmodule

// File: tb/tb_transition_decode.sv
// tb_transition_decode: scoreboard bench for transition_decode (DW=2 main instance, DW=1/3/6 round-trip instances).
module tb_transition_decode;
    localparam int NA = 6;
    localparam int DW = 2;
    localparam int S  = NA / DW;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, out_valid, out_ready, err_out, busy;
    logic [NA-1:0] P_in, N_in, A_out;
    logic [NA:0]   exp_q[$];
    int            d_chk, d_miss, m_chk, m_miss, n_out;
    bit            start_x;
    longint        cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    transition_decode #(.NA(NA), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .P_in(P_in), .N_in(N_in),
        .out_valid(out_valid), .out_ready(out_ready), .A_out(A_out), .err_out(err_out), .busy(busy)
    );

    // Booth detector: digit i = A[i-1] - A[i] with A[-1]=0
    function automatic logic [2*NA-1:0] detect(input logic [NA-1:0] a);
        logic [NA:0]   e;
        logic [NA-1:0] p, n;
        e = {a, 1'b0};
        for (int i = 0; i < NA; i++) begin
            p[i] = e[i] & ~e[i+1];
            n[i] = ~e[i] & e[i+1];
        end
        return {p, n};
    endfunction

    // A[i] is the parity of all transitions at or below i; the pair is legal iff re-detecting A reproduces it
    function automatic logic [NA:0] model(input logic [NA-1:0] p, input logic [NA-1:0] n);
        logic [NA-1:0] a;
        for (int i = 0; i < NA; i++) a[i] = ^((p | n) & NA'((1 << (i + 1)) - 1));
        return {detect(a) != {p, n}, a};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        d_chk++;
        if (act !== req) begin
            d_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NA-1:0] p, input logic [NA-1:0] n, input bit push,
                        input logic [NA:0] exp_v, input bit rnd);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'(1));
            return;
        end
        P_in = p;
        N_in = n;
        in_valid = 1'b1;
        if (push) exp_q.push_back(exp_v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        check("out_valid_rise", 32'(out_valid), 32'(1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || !in_ready) && t < 100) begin
            tick();
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
    endtask

    // scoreboard monitor for the main instance
    initial begin
        logic [NA:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_out++;
                m_chk++;
                if (exp_q.size() == 0) begin
                    m_miss++;
                    $display("FAIL result: unexpected output err/A=%b/%h", err_out, A_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({err_out, A_out} !== e) begin
                        m_miss++;
                        $display("FAIL result: got err/A=%b/%h, expected %b/%h", err_out, A_out, e[NA], e[NA-1:0]);
                    end
                end
            end
        end
    end

    // round-trip instances for the other digit-per-clock settings
    for (genvar k = 0; k < 3; k++) begin : g_x
        localparam int D = k == 0 ? 1 : k == 1 ? 3 : 6;
        logic          xv, xr, xo, xe, xb;
        logic [NA-1:0] xp, xn, xa;
        logic [NA-1:0] q[$];
        int            chk, miss;
        bit            done;

        transition_decode #(.NA(NA), .DW(D)) u (
            .clk(clk), .rst_n(rst_n), .in_valid(xv), .in_ready(xr), .P_in(xp), .N_in(xn),
            .out_valid(xo), .out_ready(1'b1), .A_out(xa), .err_out(xe), .busy(xb)
        );

        initial begin
            int t;
            xv = 1'b0;
            xp = '0;
            xn = '0;
            wait (start_x);
            for (int a = 0; a < 64; a++) begin
                t = 0;
                @(posedge clk);
                #1;
                while (!xr && t < 50) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                {xp, xn} = detect(NA'(a));
                q.push_back(NA'(a));
                xv = 1'b1;
                @(posedge clk);
                #1;
                xv = 1'b0;
            end
        end

        initial begin
            logic [NA-1:0] e;
            forever begin
                @(negedge clk);
                if (xo) begin
                    chk++;
                    if (q.size() == 0) begin
                        miss++;
                        $display("FAIL rt_dw%0d: unexpected output A=%h", D, xa);
                    end else begin
                        e = q.pop_front();
                        if ({xb, xe, xa} !== {1'b1, 1'b0, e}) begin
                            miss++;
                            $display("FAIL rt_dw%0d: got busy/err/A=%b/%b/%h, expected 1/0/%h", D, xb, xe, xa, e);
                        end
                    end
                    if (chk == 64) done = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [NA-1:0] pp, nn, av, cap_a;
        logic          cap_e;
        int            lat, acc, n0, t, tot, bad;
        longint        last;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        P_in = '0;
        N_in = '0;
        start_x = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_A", 32'(A_out), 32'(0));
        check("rst_err", 32'(err_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // worked example and latency
        out_ready = 1'b1;
        send(6'b010010, 6'b100101, 1'b1, {1'b0, 6'b101101}, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(S));
        check("ex1_A", 32'(A_out), 32'(6'b101101));
        check("ex1_err", 32'(err_out), 32'(0));
        drain();

        // illegal encodings
        send(6'b000001, 6'b000000, 1'b1, model(6'b000001, 6'b000000), 1'b0);
        wait_out();
        check("p_at_lsb_A", 32'(A_out), 32'(6'b111111));
        check("p_at_lsb_err", 32'(err_out), 32'(1));
        send(6'b000100, 6'b000100, 1'b1, model(6'b000100, 6'b000100), 1'b0);
        wait_out();
        check("p_and_n_err", 32'(err_out), 32'(1));
        drain();

        // backpressure
        out_ready = 1'b0;
        {pp, nn} = detect(6'b110010);
        send(pp, nn, 1'b1, {1'b0, 6'b110010}, 1'b0);
        wait_out();
        cap_a = A_out;
        cap_e = err_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_A", 32'(A_out), 32'(cap_a));
            check("bp_err", 32'(err_out), 32'(cap_e));
            check("bp_in_ready", 32'(in_ready), 32'(0));
        end
        tick();
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(in_ready), 32'(1));
        check("bp_release_valid", 32'(out_valid), 32'(0));
        check("bp_kept_A", 32'(A_out), 32'(6'b110010));

        // reset in the middle of RUN
        {pp, nn} = detect(6'b011011);
        send(pp, nn, 1'b0, '0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(out_valid), 32'(0));
        end
        check("midrst_A", 32'(A_out), 32'(0));
        check("midrst_err", 32'(err_out), 32'(0));
        check("midrst_ready", 32'(in_ready), 32'(1));
        tick();

        // exhaustive round trip
        for (int a = 0; a < 64; a++) begin
            {pp, nn} = detect(NA'(a));
            send(pp, nn, 1'b1, {1'b0, NA'(a)}, 1'b0);
        end
        drain();

        // in_valid held high: one acceptance every S+2 cycles
        out_ready = 1'b1;
        in_valid = 1'b1;
        n0 = n_out;
        acc = 0;
        t = 0;
        last = 0;
        while (acc < 10 && t < 200) begin
            if (in_ready) begin
                av = NA'($urandom);
                {pp, nn} = detect(av);
                P_in = pp;
                N_in = nn;
                exp_q.push_back({1'b0, av});
                if (acc > 0) check("b2b_period", 32'(cyc - last), 32'(S + 2));
                last = cyc;
                acc++;
            end
            tick();
            t++;
        end
        in_valid = 1'b0;
        drain();
        check("b2b_count", 32'(n_out - n0), 32'(10));

        // random legal and arbitrary pairs with random backpressure and gaps
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                {pp, nn} = detect(NA'($urandom));
            end else begin
                pp = NA'($urandom & $urandom);
                nn = NA'($urandom & $urandom);
            end
            send(pp, nn, 1'b1, model(pp, nn), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        drain();

        start_x = 1'b1;
        t = 0;
        while (!(g_x[0].done && g_x[1].done && g_x[2].done) && t < 3000) begin
            tick();
            t++;
        end
        check("rt_other_dw_done", 32'({g_x[0].done, g_x[1].done, g_x[2].done}), 32'(3'b111));

        tot = d_chk + m_chk + g_x[0].chk + g_x[1].chk + g_x[2].chk;
        bad = d_miss + m_miss + g_x[0].miss + g_x[1].miss + g_x[2].miss;
        $display("== %0d vectors applied, %0d miscompares ==", tot, bad);
        $finish;
    end
endmodule
